// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clock-stage reset/lock sequencer.
// State encoding, output widths and small elaboration-time functions.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    RESET_STAGE = 2'd0,
    WAIT_LOCK   = 2'd1,
    RUNNING     = 2'd2,
    FAIL        = 2'd3
  } state_e;

  localparam int IDX_W      = 3;
  localparam int RETRY_W    = 4;
  localparam int LOST_W     = 8;
  localparam int MAX_STAGES = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index of the lowest cleared bit; callers only use it when one exists.
  function automatic logic [IDX_W-1:0] lowest_zero(
    input logic [MAX_STAGES-1:0] v
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (!v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_gen_lock_filter.sv
// Per-stage lock conditioning: 2-flop synchroniser plus a high-run filter.
// The output falls as soon as the synchronised lock is seen low.
module clk_gen_lock_filter
  import clk_gen_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic LOCKED_IN,
  output logic LOCKED_OUT
);

  localparam int CW = clog2(FILTER_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= LOCKED_IN;
      r_s2 <= r_s1;
      if (!r_s2) begin
        r_cnt <= '0;
      end else if (r_cnt < CW'(FILTER_CYCLES - 1)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign LOCKED_OUT = r_s2 && (r_cnt >= CW'(FILTER_CYCLES - 1));

endmodule

// File: rtl/clk_gen_rst_seq.sv
// Reset/lock sequencer for a chain of cascaded clock-synthesis stages.
// Releases stage resets in order, re-sequences on lock loss, retries on timeout.
module clk_gen_rst_seq
  import clk_gen_pkg::*;
#(
  parameter int N_STAGES         = 2,
  parameter int RST_PULSE_CYCLES = 3,
  parameter int FILTER_CYCLES    = 4,
  parameter int LOCK_TIMEOUT     = 65535,
  parameter int MAX_RETRIES      = 7
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_STAGES-1:0] STAGE_LOCKED_IN,
  input  logic                FORCE_RESTART_IN,
  output logic [N_STAGES-1:0] STAGE_RST_OUT,
  output logic                ALL_LOCKED_OUT,
  output logic                FAIL_OUT,
  output logic [2:0]          STAGE_IDX_OUT,
  output logic [3:0]          RETRY_CNT_OUT,
  output logic [7:0]          LOST_CNT_OUT
);

  localparam int PW = clog2(RST_PULSE_CYCLES + 1);
  localparam int TW = clog2(LOCK_TIMEOUT + 1);

  logic [N_STAGES-1:0] w_lock_f;

  for (genvar g = 0; g < N_STAGES; g++) begin : g_filt
    clk_gen_lock_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt (
      .CLK       (CLK),
      .RST       (RST),
      .LOCKED_IN (STAGE_LOCKED_IN[g]),
      .LOCKED_OUT(w_lock_f[g])
    );
  end

  state_e               r_state, w_state;
  logic [IDX_W-1:0]     r_k, w_k;
  logic [PW-1:0]        r_pcnt, w_pcnt;
  logic [TW-1:0]        r_tcnt, w_tcnt;
  logic [RETRY_W-1:0]   r_retry, w_retry;
  logic [LOST_W-1:0]    r_lost, w_lost;
  logic [N_STAGES-1:0]  r_stage_rst, w_stage_rst;
  logic                 r_all, w_all;
  logic                 r_fail, w_fail;

  logic [MAX_STAGES-1:0] w_lock8;
  logic [MAX_STAGES-1:0] w_low_ok;
  logic                  w_lower_lost;
  logic [IDX_W-1:0]      w_lower_idx;
  logic                  w_any_lost;
  logic [IDX_W-1:0]      w_any_idx;
  logic                  w_lock_k;
  logic [RETRY_W-1:0]    w_retry_inc;
  logic [LOST_W-1:0]     w_lost_inc;

  // Absent stages read as locked so the loss scan ignores them.
  always_comb begin
    w_lock8 = '1;
    w_lock8[N_STAGES-1:0] = w_lock_f;
    for (int i = 0; i < MAX_STAGES; i++) begin
      w_low_ok[i] = (IDX_W'(i) >= r_k) ? 1'b1 : w_lock8[i];
    end
    w_lower_lost = ~&w_low_ok;
    w_lower_idx  = lowest_zero(w_low_ok);
    w_any_lost   = ~&w_lock8;
    w_any_idx    = lowest_zero(w_lock8);
    w_lock_k     = w_lock8[r_k];
    w_retry_inc  = (&r_retry) ? r_retry : r_retry + RETRY_W'(1);
    w_lost_inc   = (&r_lost) ? r_lost : r_lost + LOST_W'(1);
  end

  always_comb begin
    w_state = r_state;
    w_k     = r_k;
    w_pcnt  = r_pcnt;
    w_tcnt  = r_tcnt;
    w_retry = r_retry;
    w_lost  = r_lost;

    if (FORCE_RESTART_IN) begin
      w_state = RESET_STAGE;
      w_k     = '0;
      w_pcnt  = '0;
      w_retry = '0;
    end else begin
      unique case (r_state)
        RESET_STAGE: begin
          if (r_pcnt == PW'(RST_PULSE_CYCLES - 1)) begin
            w_state = WAIT_LOCK;
            w_tcnt  = '0;
          end else begin
            w_pcnt = r_pcnt + PW'(1);
          end
        end
        WAIT_LOCK: begin
          if (w_lower_lost) begin
            w_lost  = w_lost_inc;
            w_retry = '0;
            w_k     = w_lower_idx;
            w_state = RESET_STAGE;
            w_pcnt  = '0;
          end else if (w_lock_k) begin
            w_retry = '0;
            if (r_k == IDX_W'(N_STAGES - 1)) begin
              w_state = RUNNING;
            end else begin
              w_k     = r_k + IDX_W'(1);
              w_state = RESET_STAGE;
              w_pcnt  = '0;
            end
          end else if (r_tcnt == TW'(LOCK_TIMEOUT - 1)) begin
            w_retry = w_retry_inc;
            w_pcnt  = '0;
            if (w_retry_inc == RETRY_W'(MAX_RETRIES)) begin
              w_state = FAIL;
            end else begin
              w_state = RESET_STAGE;
            end
          end else begin
            w_tcnt = r_tcnt + TW'(1);
          end
        end
        RUNNING: begin
          if (w_any_lost) begin
            w_lost  = w_lost_inc;
            w_k     = w_any_idx;
            w_state = RESET_STAGE;
            w_pcnt  = '0;
          end
        end
        FAIL: begin
          w_state = FAIL;
        end
        default: begin
          w_state = RESET_STAGE;
        end
      endcase
    end

    // Output registers load the decode of the next state.
    for (int i = 0; i < N_STAGES; i++) begin
      unique case (w_state)
        RESET_STAGE, FAIL: w_stage_rst[i] = (IDX_W'(i) >= w_k);
        WAIT_LOCK:         w_stage_rst[i] = (IDX_W'(i) > w_k);
        default:           w_stage_rst[i] = 1'b0;
      endcase
    end
    w_all  = (w_state == RUNNING);
    w_fail = (w_state == FAIL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= RESET_STAGE;
      r_k         <= '0;
      r_pcnt      <= '0;
      r_tcnt      <= '0;
      r_retry     <= '0;
      r_lost      <= '0;
      r_stage_rst <= '1;
      r_all       <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_k         <= w_k;
      r_pcnt      <= w_pcnt;
      r_tcnt      <= w_tcnt;
      r_retry     <= w_retry;
      r_lost      <= w_lost;
      r_stage_rst <= w_stage_rst;
      r_all       <= w_all;
      r_fail      <= w_fail;
    end
  end

  assign STAGE_RST_OUT  = r_stage_rst;
  assign ALL_LOCKED_OUT = r_all;
  assign FAIL_OUT       = r_fail;
  assign STAGE_IDX_OUT  = r_k;
  assign RETRY_CNT_OUT  = r_retry;
  assign LOST_CNT_OUT   = r_lost;

endmodule
